btn_conditioner: RTL and testbench

Parametrised N-channel input conditioner for the emulator's board buttons (A, B, up, down, left, right and any future switches). Per channel it synchronises, optionally inverts and debounces the raw pad, then generates press, release and auto-repeat events. Events are queued into a small FIFO read over a valid/ready handshake. It sits between the board pins and the MCU port inputs: `state_out` drives the port pins, and the event stream serves the debug/host logic.

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_debounce_ch.sv | 80 ++++++++
 rtl/btn_conditioner.sv | 158 +++++++++++++++
 tb/tb_btn_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared event encodings, event record and counter sizing helper for the
// board button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  localparam int CH_MAX_W = 5;

  typedef struct packed {
    evt_type_t           etype;
    logic [CH_MAX_W-1:0] ch;
  } evt_t;

  // Bits needed to hold every value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, polarity fix, debounce and auto-repeat
// timer. The *_set outputs are combinational and fire on the edge state moves.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16000,
  parameter logic INVERT          = 1'b0,
  parameter bit   REPEAT_EN       = 1'b1,
  parameter int   REPEAT_DELAY    = 8000000,
  parameter int   REPEAT_PERIOD   = 1600000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic state,
  output logic press_set,
  output logic release_set,
  output logic repeat_set
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [DW-1:0]          db_cnt_reg;
  logic                   level;
  logic                   toggle;

  assign level       = sync_reg[SYNC_STAGES-1] ^ INVERT;
  assign toggle      = (level != state) && (db_cnt_reg == DB_LAST);
  assign press_set   = toggle & ~state;
  assign release_set = toggle & state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg   <= {SYNC_STAGES{INVERT}};
      db_cnt_reg <= '0;
      state      <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      if ((level == state) || toggle)
        db_cnt_reg <= '0;
      else
        db_cnt_reg <= db_cnt_reg + DW'(1);
      if (toggle)
        state <= ~state;
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int RW = cnt_width(((REPEAT_DELAY > REPEAT_PERIOD) ?
                                     REPEAT_DELAY : REPEAT_PERIOD) - 1);
      localparam logic [RW-1:0] DLY_LOAD = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          rep_cnt_reg <= '0;
        else if (press_set)
          rep_cnt_reg <= DLY_LOAD;
        else if (release_set || !state)
          rep_cnt_reg <= '0;
        else if (rep_cnt_reg == '0)
          rep_cnt_reg <= PER_LOAD;
        else
          rep_cnt_reg <= rep_cnt_reg - RW'(1);
      end

      // A repeat that would coincide with the release edge is suppressed.
      assign repeat_set = state && !release_set && (rep_cnt_reg == '0);
    end else begin : g_no_rep
      assign repeat_set = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button conditioner: per-channel debounce, pending event flags,
// fixed-priority arbiter and a small event FIFO with a registered head.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int                  CHANNELS        = 8,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 16000,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = '0,
  parameter bit                  REPEAT_EN       = 1'b1,
  parameter int                  REPEAT_DELAY    = 8000000,
  parameter int                  REPEAT_PERIOD   = 1600000,
  parameter int                  EVT_DEPTH       = 4,
  localparam int                 CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] state_out,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_W-1:0]     evt_ch,
  output logic [1:0]          evt_type,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int PW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int CW = $clog2(EVT_DEPTH + 1);

  logic [CHANNELS-1:0] press_set, release_set, repeat_set;
  logic [CHANNELS-1:0] pend_press_reg, pend_release_reg, pend_repeat_reg;
  logic [CHANNELS-1:0] serve_press, serve_release, serve_repeat;
  logic [CHANNELS-1:0] clr_press, clr_release, clr_repeat;
  evt_t                wr_evt;
  logic                any_pend, wr_en, pop, load, full, lost;
  evt_t                mem [EVT_DEPTH];
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       mem_cnt_reg;
  logic                head_valid_reg;
  evt_t                head_reg;
  logic                overflow_reg;
  logic                unused_ch_hi;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      btn_debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .INVERT          (INVERT_MASK[gi]),
        .REPEAT_EN       (REPEAT_EN),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .raw         (raw_in[gi]),
        .state       (state_out[gi]),
        .press_set   (press_set[gi]),
        .release_set (release_set[gi]),
        .repeat_set  (repeat_set[gi])
      );
    end
  endgenerate

  // Scan downwards so the lowest pending channel is the one left selected.
  always_comb begin
    serve_press   = '0;
    serve_release = '0;
    serve_repeat  = '0;
    wr_evt        = '0;
    any_pend      = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_press_reg[i] | pend_release_reg[i] | pend_repeat_reg[i]) begin
        any_pend      = 1'b1;
        serve_press   = '0;
        serve_release = '0;
        serve_repeat  = '0;
        wr_evt.ch     = CH_MAX_W'(i);
        if (pend_press_reg[i]) begin
          wr_evt.etype   = EVT_PRESS;
          serve_press[i] = 1'b1;
        end else if (pend_release_reg[i]) begin
          wr_evt.etype     = EVT_RELEASE;
          serve_release[i] = 1'b1;
        end else begin
          wr_evt.etype    = EVT_REPEAT;
          serve_repeat[i] = 1'b1;
        end
      end
    end
  end

  assign pop   = head_valid_reg & evt_ready;
  assign full  = (mem_cnt_reg + CW'(head_valid_reg)) == CW'(EVT_DEPTH);
  assign wr_en = any_pend & (~full | pop);
  assign load  = (mem_cnt_reg != '0) & (~head_valid_reg | pop);

  assign clr_press   = serve_press   & {CHANNELS{wr_en}};
  assign clr_release = serve_release & {CHANNELS{wr_en}};
  assign clr_repeat  = serve_repeat  & {CHANNELS{wr_en}};

  // Re-setting a flag that is being written out this cycle loses nothing.
  assign lost = |((press_set   & pend_press_reg   & ~clr_press)   |
                  (release_set & pend_release_reg & ~clr_release) |
                  (repeat_set  & pend_repeat_reg  & ~clr_repeat));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_press_reg   <= '0;
      pend_release_reg <= '0;
      pend_repeat_reg  <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      pend_press_reg   <= (pend_press_reg   & ~clr_press)   | press_set;
      pend_release_reg <= (pend_release_reg & ~clr_release) | release_set;
      pend_repeat_reg  <= (pend_repeat_reg  & ~clr_repeat)  | repeat_set;
      if (lost)
        overflow_reg <= 1'b1;
      else if (clr_overflow)
        overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wr_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_cnt_reg    <= '0;
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= (wr_ptr_reg == PW'(EVT_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      if (load)
        rd_ptr_reg <= (rd_ptr_reg == PW'(EVT_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      mem_cnt_reg <= mem_cnt_reg + CW'(wr_en) - CW'(load);
      if (load) begin
        head_reg       <= mem[rd_ptr_reg];
        head_valid_reg <= 1'b1;
      end else if (pop) begin
        head_valid_reg <= 1'b0;
      end
    end
  end

  assign evt_valid    = head_valid_reg;
  assign evt_ch       = head_reg.ch[CH_W-1:0];
  assign evt_type     = head_reg.etype;
  assign overflow     = overflow_reg;
  assign unused_ch_hi = |(head_reg.ch >> CH_W);

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected events,
// an independent monitor pops and compares on every accepted head.
module tb_btn_conditioner;
  import btn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] raw_in = 4'b0000;
  logic [3:0] state_out;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_ch;
  logic [1:0] evt_type;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop = 0;

  typedef struct {
    int ch;
    int etype;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  btn_conditioner #(
    .CHANNELS        (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .INVERT_MASK     (4'b0001),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .EVT_DEPTH       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .state_out    (state_out),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_ch       (evt_ch),
    .evt_type     (evt_type),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL evt_unexpected: got ch=%0d type=%0d, required no event", evt_ch, evt_type);
      end else begin
        mon_e = exp_q.pop_front();
        if (evt_ch != mon_e.ch || evt_type != mon_e.etype ||
            (mon_e.gap >= 0 && (cyc - last_pop) != mon_e.gap)) begin
          fails++;
          $display("FAIL evt: got ch=%0d type=%0d gap=%0d, required ch=%0d type=%0d gap=%0d",
                   evt_ch, evt_type, cyc - last_pop, mon_e.ch, mon_e.etype, mon_e.gap);
        end else begin
          $display("PASS evt ch=%0d type=%0d gap=%0d", evt_ch, evt_type, cyc - last_pop);
        end
      end
      last_pop = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int ch, input int t, input int gap);
    exp_q.push_back('{ch, t, gap});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("PASS %s: %0h", name, act);
    end
  endtask

  initial begin
    tick(3);
    check("rst_state", 32'(state_out), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_ch", 32'(evt_ch), 0);
    check("rst_type", 32'(evt_type), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;

    // ch0 is active-low: a low pad after reset reads as pressed
    evt_ready = 1'b1;
    expect_evt(0, EVT_PRESS, -1);
    expect_evt(0, EVT_RELEASE, 8);
    tick(8);
    raw_in[0] = 1'b1;
    tick(10);
    check("t1_state", 32'(state_out), 0);

    tick(4);
    raw_in[2] = 1'b1;
    tick(3);
    raw_in[2] = 1'b0;
    tick(10);
    check("t2_glitch_state", 32'(state_out), 0);
    expect_evt(2, EVT_PRESS, -1);
    expect_evt(2, EVT_RELEASE, 6);
    raw_in[2] = 1'b1;
    tick(6);
    raw_in[2] = 1'b0;
    tick(14);
    check("t2_pulse_state", 32'(state_out), 0);

    expect_evt(1, EVT_PRESS, -1);
    expect_evt(1, EVT_REPEAT, 20);
    expect_evt(1, EVT_REPEAT, 5);
    expect_evt(1, EVT_REPEAT, 5);
    expect_evt(1, EVT_REPEAT, 5);
    expect_evt(1, EVT_RELEASE, 5);
    raw_in[1] = 1'b1;
    tick(20);
    check("t3_held_state", 32'(state_out), 32'h2);
    tick(20);
    raw_in[1] = 1'b0;
    tick(20);
    check("t3_rel_state", 32'(state_out), 0);

    expect_evt(0, EVT_PRESS, -1);
    expect_evt(3, EVT_PRESS, 1);
    raw_in = 4'b1000;
    tick(8);
    check("t4_state", 32'(state_out), 32'h9);
    expect_evt(0, EVT_RELEASE, -1);
    expect_evt(3, EVT_RELEASE, 1);
    raw_in = 4'b0001;
    tick(12);
    check("t4_rel_state", 32'(state_out), 0);

    // Backpressure: four presses fill the FIFO, later events wait as flags
    evt_ready = 1'b0;
    raw_in = 4'b1110;
    tick(8);
    raw_in = 4'b1101;
    tick(13);
    check("t5_valid", 32'(evt_valid), 1);
    check("t5_ovf_clear", 32'(overflow), 0);
    check("t5_state", 32'(state_out), 32'hC);
    tick(13);
    check("t5_ovf_set", 32'(overflow), 1);
    raw_in = 4'b0001;
    tick(10);
    check("t5_state_rel", 32'(state_out), 0);
    check("t5_ovf_sticky", 32'(overflow), 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t5_ovf_cleared", 32'(overflow), 0);
    expect_evt(0, EVT_PRESS, -1);
    expect_evt(1, EVT_PRESS, 1);
    expect_evt(2, EVT_PRESS, 1);
    expect_evt(3, EVT_PRESS, 1);
    expect_evt(0, EVT_RELEASE, 1);
    expect_evt(1, EVT_RELEASE, 1);
    expect_evt(2, EVT_RELEASE, 1);
    expect_evt(2, EVT_REPEAT, 1);
    expect_evt(3, EVT_RELEASE, 1);
    expect_evt(3, EVT_REPEAT, 1);
    evt_ready = 1'b1;
    tick(20);
    check("t5_drained", 32'(exp_q.size()), 0);

    evt_ready = 1'b0;
    raw_in = 4'b0111;
    tick(10);
    check("t6_half_full", 32'(evt_valid), 1);
    raw_in[3] = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    check("t6_state", 32'(state_out), 0);
    check("t6_valid", 32'(evt_valid), 0);
    check("t6_ch", 32'(evt_ch), 0);
    check("t6_type", 32'(evt_type), 0);
    check("t6_ovf", 32'(overflow), 0);
    raw_in = 4'b0001;
    tick(3);
    rst = 1'b1;
    evt_ready = 1'b1;
    tick(30);
    check("t6_post_state", 32'(state_out), 0);
    check("t6_no_events", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
